// File: rtl/fa_rev_serial.sv
// Digit-serial reversible full adder: forward S=A+B+C0, backward B=S-A-C0, Z toggled by the carry; NDIG-cycle latency.
// Single transaction in flight: in_ready only in IDLE, result held in DONE until out_ready.
module fa_rev_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
`ifdef USE_POWER_PINS
  inout  wire               VDD,
  inout  wire               VSS,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_dir,
  input  logic [WIDTH-1:0]  in_p,
  input  logic [WIDTH-1:0]  in_q,
  input  logic              in_c,
  input  logic              in_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_dir,
  output logic [WIDTH-1:0]  out_p,
  output logic [WIDTH-1:0]  out_q,
  output logic              out_c,
  output logic              out_z
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (WIDTH % DIGIT != 0) begin : g_bad_digit
      $error("fa_rev_serial: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_next;
  logic             r_dir, r_c, r_z, r_cy;
  logic [WIDTH-1:0] r_p, r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_out_dir, r_out_c, r_out_z;
  logic [WIDTH-1:0] r_out_p, r_out_q;

  logic [DIGIT-1:0] w_pd, w_qd;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;
  int               w_base;

  // Digit result is written back in place; out_q only sees the completed word.
  always_comb begin
    w_base   = int'(r_cnt) * DIGIT;
    w_pd     = r_p[w_base +: DIGIT];
    w_qd     = r_q[w_base +: DIGIT];
    if (r_dir)
      w_sum = {1'b0, w_qd} - {1'b0, w_pd} - {{DIGIT{1'b0}}, r_cy};
    else
      w_sum = {1'b0, w_pd} + {1'b0, w_qd} + {{DIGIT{1'b0}}, r_cy};
    w_q_next = r_q;
    w_q_next[w_base +: DIGIT] = w_sum[DIGIT-1:0];
    w_last   = (r_cnt == CW'(NDIG - 1));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_dir     <= 1'b0;
      r_c       <= 1'b0;
      r_z       <= 1'b0;
      r_cy      <= 1'b0;
      r_p       <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_out_dir <= 1'b0;
      r_out_c   <= 1'b0;
      r_out_z   <= 1'b0;
      r_out_p   <= '0;
      r_out_q   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dir <= in_dir;
            r_p   <= in_p;
            r_q   <= in_q;
            r_c   <= in_c;
            r_z   <= in_z;
            r_cy  <= in_c;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_q   <= w_q_next;
          r_cy  <= w_sum[DIGIT];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_out_q   <= w_q_next;
            r_out_p   <= r_p;
            r_out_c   <= r_c;
            r_out_dir <= r_dir;
            // Borrow-out of S-A-C0 equals carry-out of A+B+C0, so Z restores on the way back.
            r_out_z   <= r_z ^ w_sum[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_dir   = r_out_dir;
  assign out_p     = r_out_p;
  assign out_q     = r_out_q;
  assign out_c     = r_out_c;
  assign out_z     = r_out_z;

endmodule

// File: tb/tb_fa_rev_serial.sv
// Bench for fa_rev_serial: directed cases and random round trips on three WIDTH/DIGIT configurations.
module tb_fa_rev_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, in_dir, in_c, in_z;
  logic [31:0] in_p, in_q;
  int          sel;

  int n_assert = 0;
  int n_fail   = 0;

  logic        ir0, ov0, od0, oc0, oz0;
  logic [15:0] op0, oq0;
  logic        ir1, ov1, od1, oc1, oz1;
  logic [7:0]  op1, oq1;
  logic        ir2, ov2, od2, oc2, oz2;
  logic [31:0] op2, oq2;

  logic        cur_in_ready, cur_out_valid, cur_out_dir, cur_out_c, cur_out_z;
  logic [31:0] cur_out_p, cur_out_q;

  always #5 clk = ~clk;

  fa_rev_serial #(.WIDTH(16), .DIGIT(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(ir0),
    .in_dir(in_dir), .in_p(in_p[15:0]), .in_q(in_q[15:0]), .in_c(in_c), .in_z(in_z),
    .out_valid(ov0), .out_ready(out_ready && sel == 0), .out_dir(od0),
    .out_p(op0), .out_q(oq0), .out_c(oc0), .out_z(oz0));

  fa_rev_serial #(.WIDTH(8), .DIGIT(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(ir1),
    .in_dir(in_dir), .in_p(in_p[7:0]), .in_q(in_q[7:0]), .in_c(in_c), .in_z(in_z),
    .out_valid(ov1), .out_ready(out_ready && sel == 1), .out_dir(od1),
    .out_p(op1), .out_q(oq1), .out_c(oc1), .out_z(oz1));

  fa_rev_serial #(.WIDTH(32), .DIGIT(2)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(ir2),
    .in_dir(in_dir), .in_p(in_p), .in_q(in_q), .in_c(in_c), .in_z(in_z),
    .out_valid(ov2), .out_ready(out_ready && sel == 2), .out_dir(od2),
    .out_p(op2), .out_q(oq2), .out_c(oc2), .out_z(oz2));

  always_comb begin
    cur_in_ready = ir0; cur_out_valid = ov0; cur_out_dir = od0;
    cur_out_c = oc0; cur_out_z = oz0;
    cur_out_p = {16'b0, op0}; cur_out_q = {16'b0, oq0};
    if (sel == 1) begin
      cur_in_ready = ir1; cur_out_valid = ov1; cur_out_dir = od1;
      cur_out_c = oc1; cur_out_z = oz1;
      cur_out_p = {24'b0, op1}; cur_out_q = {24'b0, oq1};
    end else if (sel == 2) begin
      cur_in_ready = ir2; cur_out_valid = ov2; cur_out_dir = od2;
      cur_out_c = oc2; cur_out_z = oz2;
      cur_out_p = op2; cur_out_q = oq2;
    end
  end

  function automatic int cfg_width(input int s);
    return (s == 0) ? 16 : (s == 1) ? 8 : 32;
  endfunction

  function automatic int cfg_ndig(input int s);
    return (s == 0) ? 4 : (s == 1) ? 1 : 16;
  endfunction

  // Reference: whole-word modular arithmetic, carry/borrow taken from the full-width result.
  function automatic void model(input bit dir, input logic [63:0] a, input logic [63:0] b,
                                input bit c, input bit z, input int w,
                                output logic [63:0] q, output bit zo);
    logic [63:0] m;
    logic [63:0] t;
    m = (64'd1 << w) - 64'd1;
    if (!dir) begin
      t  = a + b + 64'(c);
      q  = t & m;
      zo = z ^ (t > m);
    end else begin
      t  = b - a - 64'(c);
      q  = t & m;
      zo = z ^ (b < a + 64'(c));
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_txn(input bit dir, input logic [31:0] a_in, input logic [31:0] b_in,
                         input bit c, input bit z, input int stall,
                         output logic [31:0] rq, output bit rz);
    int          w, nd, cnt;
    logic [63:0] m, a, b, eq;
    bit          ez;
    w  = cfg_width(sel);
    nd = cfg_ndig(sel);
    m  = (64'd1 << w) - 64'd1;
    a  = {32'b0, a_in} & m;
    b  = {32'b0, b_in} & m;
    model(dir, a, b, c, z, w, eq, ez);

    @(negedge clk);
    check("in_ready_idle", cur_in_ready, 1);
    in_dir = dir; in_p = a[31:0]; in_q = b[31:0]; in_c = c; in_z = z; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_dir = ~dir; in_p = $urandom; in_q = $urandom; in_c = 1'($urandom); in_z = 1'($urandom);
    cnt = 0;
    while (!cur_out_valid && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, nd);
    check("out_q", cur_out_q, eq);
    check("out_p", cur_out_p, a);
    check("out_c", cur_out_c, c);
    check("out_z", cur_out_z, ez);
    check("out_dir", cur_out_dir, dir);
    repeat (stall) begin
      in_valid = 1'($urandom);
      in_p = $urandom;
      @(negedge clk);
      check("stall_valid", cur_out_valid, 1);
      check("stall_in_ready", cur_in_ready, 0);
      check("stall_out_q", cur_out_q, eq);
      check("stall_out_z", cur_out_z, ez);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", cur_out_valid, 0);
    check("release_in_ready", cur_in_ready, 1);
    check("release_hold_q", cur_out_q, eq);
    rq = cur_out_q;
    rz = cur_out_z;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rq, rq2, a, b;
    bit          rz, rz2, c, z;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_dir = 1'b0;
    in_p = '0; in_q = '0; in_c = 1'b0; in_z = 1'b0; sel = 0;
    #23;
    check("rst_in_ready", cur_in_ready, 1);
    check("rst_out_valid", cur_out_valid, 0);
    check("rst_out_q", cur_out_q, 0);
    check("rst_out_p", cur_out_p, 0);
    check("rst_out_z", cur_out_z, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(1'b0, 32'h1234, 32'h4321, 1'b0, 1'b0, 0, rq, rz);
    check("dir_fwd_q", rq, 32'h5555);
    run_txn(1'b0, 32'hFFFF, 32'h0001, 1'b1, 1'b1, 2, rq, rz);
    check("ovf_q", rq, 32'h0001);
    check("ovf_z", rz, 0);
    run_txn(1'b1, 32'hFFFF, rq, 1'b1, rz, 5, rq2, rz2);
    check("bwd_q", rq2, 32'h0001);
    check("bwd_z", rz2, 1);

    // Abort mid-RUN: outputs currently hold the nonzero backward result.
    @(negedge clk);
    in_dir = 1'b0; in_p = 32'hAAAA; in_q = 32'h5555; in_c = 1'b1; in_z = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", cur_out_valid, 0);
    check("abort_out_q", cur_out_q, 0);
    check("abort_out_p", cur_out_p, 0);
    check("abort_out_c", cur_out_c, 0);
    check("abort_out_z", cur_out_z, 0);
    check("abort_out_dir", cur_out_dir, 0);
    check("abort_in_ready", cur_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (cfg_ndig(0) + 3) begin
      @(negedge clk);
      check("post_abort_valid", cur_out_valid, 0);
      check("post_abort_in_ready", cur_in_ready, 1);
    end

    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int i = 0; i < 200; i++) begin
        a = $urandom; b = $urandom; c = 1'($urandom); z = 1'($urandom);
        run_txn(1'b0, a, b, c, z, $urandom_range(0, 3), rq, rz);
        run_txn(1'b1, a, rq, c, rz, $urandom_range(0, 3), rq2, rz2);
        check("rt_b", {32'b0, rq2}, {32'b0, b} & ((64'd1 << cfg_width(s)) - 64'd1));
        check("rt_z", rz2, z);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fa_rev_serial.md
Name: fa_rev_serial

Overview:
- Parametrised, digit-serial successor to the 16-bit reversible full adder (fa16_rev_ctrl).
- Performs the same bijective add/un-add over WIDTH bits, DIGIT bits per clock, with a per-transaction direction bit and valid/ready handshakes on both sides.
- Sits between the reversible PE datapath and its controller. Forward output fed back with dir=1 must reproduce the original operands exactly.

Parameters:
- WIDTH, 16, operand width in bits.
- DIGIT, 4, bits processed per clock. WIDTH % DIGIT must be 0, otherwise elaboration error. NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- VDD, VSS  inout  1  power pins, present only under USE_POWER_PINS.
- in_valid  input  1  operand presented.
- in_ready  output  1  block accepts operands; high only in IDLE.
- in_dir  input  1  0 = forward (add), 1 = backward (un-add).
- in_p  input  WIDTH  operand A in both directions.
- in_q  input  WIDTH  B when forward, S when backward.
- in_c  input  1  carry-in C0.
- in_z  input  1  ancilla Z (forward) or Z^carry (backward).
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes result.
- out_dir  output  1  direction of the held result.
- out_p  output  WIDTH  A, passed through unchanged.
- out_q  output  WIDTH  S when forward, B when backward.
- out_c  output  1  C0, passed through.
- out_z  output  1  Z XOR carry-out of A+B+C0.

Behaviour:
- Reset (async assert, sync release by the system):
  - state = IDLE; in_ready = 1.
  - out_valid = 0; out_dir, out_p, out_q, out_c, out_z = 0.
  - Digit counter and running carry/borrow = 0.
- Accept: on the edge where in_valid && in_ready, latch dir, p, q, c and z into working registers and go to RUN. The digit counter is cleared and carry/borrow is preset to in_c.
- RUN: one digit per edge, LSB digit first.
  - Forward: digit of q = p_d + q_d + cy; cy = carry-out.
  - Backward: digit of q = q_d - p_d - bw; bw = borrow-out.
  - After NDIG RUN edges, out_q holds the full result. out_z = z ^ final cy/bw (borrow-out of S-A-C0 equals carry-out of A+B+C0). out_p = p, out_c = c, out_dir = dir.
  - On that edge the state moves to DONE and out_valid goes high. out_valid is therefore visible NDIG cycles after the accept edge.
- Arithmetic: modulo 2^WIDTH. Intermediate carry/borrow is 1 bit. Partial results are never visible on out_q while out_valid = 0; out_q is only loaded as a whole, or via a shadow register.
- DONE:
  - Outputs are held stable while out_ready = 0, for any duration.
  - On the edge with out_ready = 1: out_valid falls and state goes to IDLE. Output data registers keep their last value.
- in_ready = (state == IDLE), combinational from state.
  - in_valid in RUN or DONE is ignored; no queuing.
  - Minimum issue interval is NDIG+2 cycles.
- in_dir and operand changes after acceptance have no effect on the running operation.
- NDIG = 1: RUN lasts a single edge and latency is 1 cycle.
- Reset asserted mid-RUN or in DONE aborts immediately to reset values. No partial result appears after release.
- Reversibility: for any A, B, C0, Z, forward then backward returns A, B, C0, Z bit-exactly.

Test Plan:
- WIDTH=16, DIGIT=4, forward: A=0x1234, B=0x4321, C0=0, Z=0 -> out_q=0x5555, out_p=0x1234, out_c=0, out_z=0. out_valid rises exactly 4 cycles after the accept edge.
- Forward overflow: A=0xFFFF, B=0x0001, C0=1, Z=1 -> out_q=0x0001 (carry 1), out_z=0.
- Backward of that result: dir=1, p=0xFFFF, q=0x0001, c=1, z=0 -> out_q=0x0001, out_z=1, out_p=0xFFFF, out_c=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and toggle in_valid -> outputs stable, in_ready=0, no new accept. out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-RUN: drop rst_n 2 cycles after accept -> out_valid=0 and all out_* = 0 immediately. After release, in_ready=1 and no spurious out_valid.
- Random round-trip: 200 random (A, B, C0, Z) forward then backward, with random out_ready stalls -> all equal originals. Repeat for WIDTH=8/DIGIT=8 and WIDTH=32/DIGIT=2; zero mismatches.
